palette_seq: RTL
================

# palette_seq

Command-driven sequencer and port arbiter for the 16-slot palette RAM (each slot two 16-bit halves: RG at half 0, BX at half 1). Accepts palette opcodes from the command decoder through a valid/ready stream and turns them into single writes, multi-slot bursts, or a full clear. Shares the palette's single address/write port with the pixel pipeline's lookup reads, which always win. Sits between the command FIFO/decoder and the palette RAM.

## Interface
Parameters:
- SLOTS, 16, number of colour slots; fixed, address = {slot[3:0], half}
- DW, 16, command and palette data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command/data word
- cmdValid  in  1  cmd holds a word
- cmdReady  out  1  word accepted on cycle where cmdValid && cmdReady
- pixRe  in  1  pixel pipeline palette read this cycle
- pixAddr  in  5  pixel read address
- vblank  in  1  display in vertical blank; used only with PALSEQ_VBLANK_ONLY_EN
- palAddr  out  5  palette RAM address (muxed)
- palWData  out  16  palette write data
- palWe  out  1  palette write enable
- busy  out  1  sequencer not in IDLE or write pending
- badCmd  out  1  one-cycle pulse: header with unknown opcode dropped

## Operation
- Header opcode = cmd[15:11]. PAL_WRITE 10011: slot cmd[10:7], half cmd[6]; next accepted word is data. PAL_BURST 10101: start slot cmd[10:7], count-1 cmd[3:0]; next 2*(count) words are data, order slot RG, slot BX, slot+1 RG, ... Slot wraps 15 -> 0. PAL_CLEAR 10100: write 0 to all 32 addresses, 0 to 31. Any other opcode: word consumed, badCmd pulses next cycle, stay IDLE.
- States: IDLE, WR_DATA, BURST_DATA, CLEAR. IDLE -header-> WR_DATA/BURST_DATA/CLEAR. WR_DATA -data accepted-> IDLE. BURST_DATA -last data accepted-> IDLE. CLEAR -address 31 written-> IDLE.
- Accepted data goes into a one-entry pending-write register (addr, data, valid). Drains when granted.
- Arbitration: pixRe has absolute priority. palAddr = pixAddr when pixRe, else pending/clear address. palWe = pending valid && !pixRe (&& gate, see Configuration). palWe is 0 whenever pixRe is 1.
- cmdReady: IDLE 1; data states 1 if pending empty or pending drains this cycle; CLEAR 0.
- Header words are never written to the palette.

## Timing
- Reset values: cmdReady 0 during reset, 1 first cycle after release (IDLE); palWe 0, palAddr 0, palWData 0, busy 0, badCmd 0; state IDLE, pending invalid, counters 0. Reset mid-burst/mid-clear aborts; palette contents undefined-but-unchanged.
- Data word accepted cycle N -> palWe earliest cycle N+1; each cycle pixRe=1 delays by one.
- Throughput: one palette write per cycle with pixRe=0; burst of 16 slots completes 33 cycles after header (header + 32 data, back-to-back).
- CLEAR: 32 write cycles with pixRe=0, walking address 0..31; stalls hold address.
- palWe/palAddr/palWData combinational from registers and pixRe; no combinational path cmd -> palWe.
- Header accepted while pending write still draining: allowed; pending drains independently.
- busy high from header acceptance until pending empty and state IDLE.

## Configuration
- PALSEQ_VBLANK_ONLY_EN defined: palette writes (pending drain and CLEAR steps) additionally require vblank=1; cmdReady in data states and CLEAR progress stall outside vblank. Undefined: vblank ignored; writes whenever pixRe=0.

## Structure
- Shared package gpu_pkg: opcode constants PAL_WRITE, PAL_BURST, PAL_CLEAR, state enum, palette address width, SLOTS.
- Sub-module palette_arb: combinational pixel/write mux and grant (pixRe, pending, vblank gate). Sequencer FSM, counters and pending register in palette_seq.

## Test plan
- PAL_WRITE 0x9A40 (slot 4, BX) then data 0x1234, pixRe=0 -> palWe one cycle, palAddr 9, palWData 0x1234; busy drops next cycle.
- PAL_BURST slot 14, count 3 (0xAF02), data 1..6 -> writes addr 28,29,30,31,0,1 with data 1..6, 7 consecutive cycles after header.
- PAL_CLEAR with pixRe toggling 1/0 each cycle -> 32 zero writes to 0..31 across 64 cycles, palWe never with pixRe, palAddr=pixAddr when pixRe.
- Header 0x0000 -> consumed, badCmd single pulse, no palWe.
- Assert rst_n low mid-burst (after 3 data) -> outputs to reset values immediately; after release new PAL_WRITE works normally.
- With PALSEQ_VBLANK_ONLY_EN, vblank=0: PAL_WRITE + data -> no palWe, cmdReady 0 for following data; raise vblank -> write issues next cycle.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions for the palette path: opcodes, sequencer states,
// palette geometry and the slot/half address packing.
package gpu_pkg;

    localparam int unsigned PAL_SLOTS = 16;
    localparam int unsigned PAL_AW    = $clog2(PAL_SLOTS) + 1;

    localparam logic [4:0] PAL_WRITE = 5'b10011;
    localparam logic [4:0] PAL_BURST = 5'b10101;
    localparam logic [4:0] PAL_CLEAR = 5'b10100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_BURST_DATA,
        ST_CLEAR
    } pal_state_t;

    // Half 0 holds RG, half 1 holds BX.
    function automatic logic [PAL_AW-1:0] pal_addr(input logic [3:0] slot, input logic half);
        return {slot, half};
    endfunction

endpackage

// File: rtl/palette_seq_if.sv
// Command stream from the decoder into the palette sequencer (valid/ready).
interface palette_seq_if #(
    parameter int unsigned DW = 16
);
    logic [DW-1:0] cmd;
    logic          cmdValid;
    logic          cmdReady;

    modport master (output cmd, output cmdValid, input cmdReady);
    modport slave  (input cmd, input cmdValid, output cmdReady);
endinterface

// File: rtl/palette_arb.sv
// Palette port mux: pixel reads own the port outright; otherwise the pending
// write, or the current clear step when nothing is pending. Build option:
// PALSEQ_VBLANK_ONLY_EN additionally restricts writes to vertical blank.
module palette_arb
    import gpu_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic              i_pix_re,
    input  logic [PAL_AW-1:0] i_pix_addr,
    input  logic              i_pend_valid,
    input  logic [PAL_AW-1:0] i_pend_addr,
    input  logic [DW-1:0]     i_pend_data,
    input  logic              i_clr_active,
    input  logic [PAL_AW-1:0] i_clr_addr,
    input  logic              i_vblank,
    output logic [PAL_AW-1:0] o_addr,
    output logic [DW-1:0]     o_wdata,
    output logic              o_we,
    output logic              o_gate
);

    logic w_gate;
    logic w_clr_src;

`ifdef PALSEQ_VBLANK_ONLY_EN
    assign w_gate = !i_pix_re && i_vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = i_vblank;
    assign w_gate          = !i_pix_re;
`endif

    // A pending data write drains before the clear walk takes another step.
    assign w_clr_src = i_clr_active && !i_pend_valid;

    always_comb begin
        o_gate  = w_gate;
        o_we    = w_gate && (i_pend_valid || i_clr_active);
        o_wdata = w_clr_src ? '0 : i_pend_data;
        if (i_pix_re)
            o_addr = i_pix_addr;
        else if (w_clr_src)
            o_addr = i_clr_addr;
        else
            o_addr = i_pend_addr;
    end

endmodule

// File: rtl/palette_seq.sv
// Palette command sequencer: turns PAL_WRITE / PAL_BURST / PAL_CLEAR into
// palette writes. Build option: PALSEQ_VBLANK_ONLY_EN (writes only in vblank).
module palette_seq
    import gpu_pkg::*;
#(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned DW    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    palette_seq_if.slave      cmd_if,
    input  logic              pixRe,
    input  logic [PAL_AW-1:0] pixAddr,
    input  logic              vblank,
    output logic [PAL_AW-1:0] palAddr,
    output logic [DW-1:0]     palWData,
    output logic              palWe,
    output logic              busy,
    output logic              badCmd
);

    localparam logic [PAL_AW-1:0] LAST_ADDR = PAL_AW'(2 * SLOTS - 1);

    pal_state_t        r_state;
    logic [PAL_AW-1:0] r_addr;
    logic [4:0]        r_left;
    logic              r_pend_valid;
    logic [PAL_AW-1:0] r_pend_addr;
    logic [DW-1:0]     r_pend_data;
    logic              r_bad;

    logic              w_pix_re;
    logic              w_gate;
    logic              w_ready;
    logic              w_acc;
    logic              w_drain;
    logic              w_clr_active;
    logic              w_clr_step;
    logic [4:0]        w_opcode;

    // Reset forces the port to its idle values even while a pixel read is asserted.
    assign w_pix_re     = pixRe && rst_n;
    assign w_opcode     = cmd_if.cmd[DW-1 -: 5];
    assign w_clr_active = (r_state == ST_CLEAR);
    assign w_drain      = r_pend_valid && w_gate;
    assign w_clr_step   = w_clr_active && !r_pend_valid && w_gate;
    assign w_acc        = cmd_if.cmdValid && w_ready;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:                   w_ready = 1'b1;
            ST_WR_DATA, ST_BURST_DATA: w_ready = !r_pend_valid || w_drain;
            default:                   w_ready = 1'b0;
        endcase
        w_ready = w_ready && rst_n;
    end

    assign cmd_if.cmdReady = w_ready;
    assign busy            = (r_state != ST_IDLE) || r_pend_valid;
    assign badCmd          = r_bad;

    palette_arb #(
        .DW (DW)
    ) u_arb (
        .i_pix_re     (w_pix_re),
        .i_pix_addr   (pixAddr),
        .i_pend_valid (r_pend_valid),
        .i_pend_addr  (r_pend_addr),
        .i_pend_data  (r_pend_data),
        .i_clr_active (w_clr_active),
        .i_clr_addr   (r_addr),
        .i_vblank     (vblank),
        .o_addr       (palAddr),
        .o_wdata      (palWData),
        .o_we         (palWe),
        .o_gate       (w_gate)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_left       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_bad        <= 1'b0;
        end else begin
            r_bad <= 1'b0;
            // A load in the same cycle overrides the drain below.
            if (w_drain)
                r_pend_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        case (w_opcode)
                            PAL_WRITE: begin
                                r_addr  <= pal_addr(cmd_if.cmd[10:7], cmd_if.cmd[6]);
                                r_state <= ST_WR_DATA;
                            end
                            PAL_BURST: begin
                                r_addr  <= pal_addr(cmd_if.cmd[10:7], 1'b0);
                                r_left  <= {cmd_if.cmd[3:0], 1'b1};
                                r_state <= ST_BURST_DATA;
                            end
                            PAL_CLEAR: begin
                                r_addr  <= '0;
                                r_state <= ST_CLEAR;
                            end
                            default: r_bad <= 1'b1;
                        endcase
                    end
                end
                ST_WR_DATA: begin
                    if (w_acc) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= r_addr;
                        r_pend_data  <= cmd_if.cmd;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_BURST_DATA: begin
                    if (w_acc) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= r_addr;
                        r_pend_data  <= cmd_if.cmd;
                        r_addr       <= r_addr + PAL_AW'(1);
                        if (r_left == '0)
                            r_state <= ST_IDLE;
                        else
                            r_left <= r_left - 5'd1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_step) begin
                        if (r_addr == LAST_ADDR)
                            r_state <= ST_IDLE;
                        else
                            r_addr <= r_addr + PAL_AW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
